// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I 5-stage pipeline: captures decoder controls and
// operands, inserts load-use bubbles with an upstream stall, and honours EX flush/hold.
module id_ex_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_reg_write,
  input  logic [1:0]       id_mem_to_reg,
  input  logic             id_load,
  input  logic             id_store,
  input  logic             id_branch,
  input  logic             id_next_sel,
  input  logic             id_operand_a,
  input  logic             id_operand_b,
  input  logic             id_mem_en,
  input  logic [3:0]       id_alu_control,
  input  logic [2:0]       id_fun3,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  id_pc,
  input  logic             hold,
  input  logic             flush,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic [1:0]       ex_mem_to_reg,
  output logic             ex_load,
  output logic             ex_store,
  output logic             ex_branch,
  output logic             ex_next_sel,
  output logic             ex_operand_a,
  output logic             ex_operand_b,
  output logic             ex_mem_en,
  output logic [3:0]       ex_alu_control,
  output logic [2:0]       ex_fun3,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             ex_uses_rs1,
  output logic             ex_uses_rs2,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [XLEN-1:0]  ex_pc,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [1:0]      mem_to_reg;
    logic            load;
    logic            store;
    logic            branch;
    logic            next_sel;
    logic            operand_a;
    logic            operand_b;
    logic            mem_en;
    logic [3:0]      alu_control;
    logic [2:0]      fun3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            uses_rs1;
    logic            uses_rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } ex_t;

  ex_t              r_ex;
  ex_t              w_ex_d;
  ex_t              w_id;
  logic             w_load_use;
  logic             w_rs1_hit;
  logic             w_rs2_hit;
  logic             w_bubble;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  // Gather the ID-side bundle; an invalid ID slot must not carry live control bits.
  always_comb begin
    w_id             = '0;
    w_id.valid       = id_valid;
    w_id.fun3        = id_fun3;
    w_id.rs1         = id_rs1;
    w_id.rs2         = id_rs2;
    w_id.rd          = id_rd;
    w_id.uses_rs1    = id_uses_rs1;
    w_id.uses_rs2    = id_uses_rs2;
    w_id.rs1_data    = id_rs1_data;
    w_id.rs2_data    = id_rs2_data;
    w_id.imm         = id_imm;
    w_id.pc          = id_pc;
    if (id_valid) begin
      w_id.reg_write   = id_reg_write;
      w_id.mem_to_reg  = id_mem_to_reg;
      w_id.load        = id_load;
      w_id.store       = id_store;
      w_id.branch      = id_branch;
      w_id.next_sel    = id_next_sel;
      w_id.operand_a   = id_operand_a;
      w_id.operand_b   = id_operand_b;
      w_id.mem_en      = id_mem_en;
      w_id.alu_control = id_alu_control;
    end
  end

  // A load writing x0 produces nothing to wait for.
  always_comb begin
    w_rs1_hit  = id_uses_rs1 && (id_rs1 == r_ex.rd);
    w_rs2_hit  = id_uses_rs2 && (id_rs2 == r_ex.rd);
    w_load_use = r_ex.valid && r_ex.load && (r_ex.rd != 5'd0) &&
                 (w_rs1_hit || w_rs2_hit) && id_valid;
  end

  // Flush wins over load-use: the ID instruction is wrong-path, so no replay is needed.
  always_comb begin
    stall    = hold | (w_load_use & ~flush);
    w_bubble = flush | w_load_use;
    w_ex_d   = r_ex;
    if (!hold) begin
      if (w_bubble) begin
        w_ex_d = '0;
      end else begin
        w_ex_d = w_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex <= '0;
    end else begin
      r_ex <= w_ex_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else if (!hold) begin
      if (flush) begin
        if (r_flush_count != '1) r_flush_count <= r_flush_count + CNT_W'(1);
      end else if (w_load_use) begin
        if (r_stall_count != '1) r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign ex_valid       = r_ex.valid;
  assign ex_reg_write   = r_ex.reg_write;
  assign ex_mem_to_reg  = r_ex.mem_to_reg;
  assign ex_load        = r_ex.load;
  assign ex_store       = r_ex.store;
  assign ex_branch      = r_ex.branch;
  assign ex_next_sel    = r_ex.next_sel;
  assign ex_operand_a   = r_ex.operand_a;
  assign ex_operand_b   = r_ex.operand_b;
  assign ex_mem_en      = r_ex.mem_en;
  assign ex_alu_control = r_ex.alu_control;
  assign ex_fun3        = r_ex.fun3;
  assign ex_rs1         = r_ex.rs1;
  assign ex_rs2         = r_ex.rs2;
  assign ex_rd          = r_ex.rd;
  assign ex_uses_rs1    = r_ex.uses_rs1;
  assign ex_uses_rs2    = r_ex.uses_rs2;
  assign ex_rs1_data    = r_ex.rs1_data;
  assign ex_rs2_data    = r_ex.rs2_data;
  assign ex_imm         = r_ex.imm;
  assign ex_pc          = r_ex.pc;
  assign stall_count    = r_stall_count;
  assign flush_count    = r_flush_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a spec-level model pushes expected EX state and counters
// to a queue each cycle, popped and compared after the clock edge.
module tb_id_ex_stage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 4;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [1:0]      mem_to_reg;
    logic            load;
    logic            store;
    logic            branch;
    logic            next_sel;
    logic            operand_a;
    logic            operand_b;
    logic            mem_en;
    logic [3:0]      alu_control;
    logic [2:0]      fun3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            uses_rs1;
    logic            uses_rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } ex_t;

  typedef struct packed {
    ex_t          ex;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst, hold, flush;
  ex_t  cur;
  ex_t  obs;
  ex_t  mdl;
  logic [CW-1:0] mdl_sc, mdl_fc;
  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  logic            ex_valid, ex_reg_write, ex_load, ex_store, ex_branch, ex_next_sel;
  logic            ex_operand_a, ex_operand_b, ex_mem_en, ex_uses_rs1, ex_uses_rs2, stall;
  logic [1:0]      ex_mem_to_reg;
  logic [3:0]      ex_alu_control;
  logic [2:0]      ex_fun3;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
  logic [CW-1:0]   stall_count, flush_count;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(cur.valid), .id_reg_write(cur.reg_write), .id_mem_to_reg(cur.mem_to_reg),
    .id_load(cur.load), .id_store(cur.store), .id_branch(cur.branch),
    .id_next_sel(cur.next_sel), .id_operand_a(cur.operand_a), .id_operand_b(cur.operand_b),
    .id_mem_en(cur.mem_en), .id_alu_control(cur.alu_control), .id_fun3(cur.fun3),
    .id_rs1(cur.rs1), .id_rs2(cur.rs2), .id_rd(cur.rd),
    .id_uses_rs1(cur.uses_rs1), .id_uses_rs2(cur.uses_rs2),
    .id_rs1_data(cur.rs1_data), .id_rs2_data(cur.rs2_data), .id_imm(cur.imm), .id_pc(cur.pc),
    .hold(hold), .flush(flush),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_load(ex_load), .ex_store(ex_store), .ex_branch(ex_branch),
    .ex_next_sel(ex_next_sel), .ex_operand_a(ex_operand_a), .ex_operand_b(ex_operand_b),
    .ex_mem_en(ex_mem_en), .ex_alu_control(ex_alu_control), .ex_fun3(ex_fun3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_uses_rs1(ex_uses_rs1), .ex_uses_rs2(ex_uses_rs2),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .stall(stall), .stall_count(stall_count), .flush_count(flush_count)
  );

  assign obs = {ex_valid, ex_reg_write, ex_mem_to_reg, ex_load, ex_store, ex_branch,
                ex_next_sel, ex_operand_a, ex_operand_b, ex_mem_en, ex_alu_control, ex_fun3,
                ex_rs1, ex_rs2, ex_rd, ex_uses_rs1, ex_uses_rs2, ex_rs1_data, ex_rs2_data,
                ex_imm, ex_pc};

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic ex_t gate(input ex_t x);
    ex_t r = x;
    if (!x.valid) begin
      r.reg_write = 0; r.mem_to_reg = 0; r.load = 0; r.store = 0; r.branch = 0;
      r.next_sel = 0; r.operand_a = 0; r.operand_b = 0; r.mem_en = 0; r.alu_control = 0;
    end
    return r;
  endfunction

  // One clock: check comb stall, predict next state, push, clock, pop and compare.
  task automatic tick(input string tag);
    logic lu, st;
    exp_t e;
    #1;
    lu = mdl.valid && mdl.load && (mdl.rd != 0) && cur.valid &&
         ((cur.uses_rs1 && cur.rs1 == mdl.rd) || (cur.uses_rs2 && cur.rs2 == mdl.rd));
    st = hold | (lu & ~flush);
    if (!rst) chk({tag, "_stall"}, 192'(stall), 192'(st));
    if (rst) begin
      mdl = '0; mdl_sc = 0; mdl_fc = 0;
    end else if (hold) begin
      mdl = mdl;
    end else if (flush) begin
      mdl = '0;
      if (mdl_fc != '1) mdl_fc++;
    end else if (lu) begin
      mdl = '0;
      if (mdl_sc != '1) mdl_sc++;
    end else begin
      mdl = gate(cur);
    end
    q.push_back('{ex: mdl, sc: mdl_sc, fc: mdl_fc});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, "_ex"}, 192'(obs), 192'(e.ex));
    chk({tag, "_scnt"}, 192'(stall_count), 192'(e.sc));
    chk({tag, "_fcnt"}, 192'(flush_count), 192'(e.fc));
  endtask

  function automatic ex_t mk(input logic v, input logic ld, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic u1, input logic u2, input logic [31:0] pc);
    ex_t x = '0;
    x.valid = v; x.load = ld; x.reg_write = 1'b1; x.mem_en = ld; x.mem_to_reg = ld ? 2'd1 : 2'd0;
    x.rd = rd; x.rs1 = rs1; x.rs2 = rs2; x.uses_rs1 = u1; x.uses_rs2 = u2;
    x.fun3 = ld ? 3'b010 : 3'b000; x.rs1_data = 32'd5; x.rs2_data = 32'd7;
    x.imm = 32'h10; x.pc = pc;
    return x;
  endfunction

  initial begin
    mdl = '0; mdl_sc = 0; mdl_fc = 0;
    rst = 1; hold = 1; flush = 1;
    cur = '1;
    tick("reset");
    rst = 0; hold = 0; flush = 0;
    cur = mk(1, 1, 5, 5, 5, 1, 1, 32'h4);
    cur.valid = 0;
    #1 chk("reset_stall_zero", 192'(stall), 192'(0));

    // add x3,x1,x2
    cur = mk(1, 0, 3, 1, 2, 1, 1, 32'h100);
    tick("pass");
    chk("pass_rd", 192'(ex_rd), 192'(3));
    chk("pass_rs1d", 192'(ex_rs1_data), 192'(5));
    chk("pass_rs2d", 192'(ex_rs2_data), 192'(7));
    chk("pass_valid", 192'(ex_valid), 192'(1));
    chk("pass_alu", 192'(ex_alu_control), 192'(0));

    // lw x5 then dependent add x6,x5,x1
    cur = mk(1, 1, 5, 1, 0, 1, 0, 32'h104);
    tick("lw5");
    cur = mk(1, 0, 6, 5, 1, 1, 1, 32'h108);
    #1 chk("lu_stall_hi", 192'(stall), 192'(1));
    tick("lu_bubble");
    chk("lu_bub_valid", 192'(ex_valid), 192'(0));
    chk("lu_bub_rw", 192'(ex_reg_write), 192'(0));
    chk("lu_scnt1", 192'(stall_count), 192'(1));
    tick("lu_replay");
    chk("lu_replay_rd", 192'(ex_rd), 192'(6));
    chk("lu_replay_valid", 192'(ex_valid), 192'(1));

    // lw x0 then reader of x0
    cur = mk(1, 1, 0, 1, 0, 1, 0, 32'h10c);
    tick("lw0");
    cur = mk(1, 0, 7, 0, 0, 1, 1, 32'h110);
    tick("x0_read");
    // lw x5 then lui x5 (no source reads)
    cur = mk(1, 1, 5, 1, 0, 1, 0, 32'h114);
    tick("lw5b");
    cur = mk(1, 0, 5, 5, 5, 0, 0, 32'h118);
    #1 chk("lui_no_stall", 192'(stall), 192'(0));
    tick("lui");

    // flush beats load-use
    cur = mk(1, 1, 5, 1, 0, 1, 0, 32'h11c);
    tick("lw5c");
    cur = mk(1, 0, 6, 5, 1, 1, 1, 32'h120);
    flush = 1;
    tick("flush_lu");
    chk("flush_lu_fcnt", 192'(flush_count), 192'(1));
    chk("flush_lu_scnt", 192'(stall_count), 192'(1));
    flush = 0;

    // hold outranks flush
    cur = mk(1, 0, 3, 1, 2, 1, 1, 32'h124);
    tick("pre_hold");
    hold = 1; flush = 1;
    cur = mk(1, 0, 9, 8, 8, 1, 1, 32'h128);
    for (int i = 0; i < 3; i++) tick("hold");
    chk("hold_frozen_pc", 192'(ex_pc), 192'(32'h124));
    hold = 0;
    tick("hold_release");
    chk("hold_rel_valid", 192'(ex_valid), 192'(0));
    flush = 0;

    // invalid ID: fields pass, controls forced low
    cur = mk(0, 1, 12, 3, 4, 1, 1, 32'h200);
    cur.alu_control = 4'hA; cur.store = 1; cur.branch = 1;
    tick("invalid");
    chk("inv_rd", 192'(ex_rd), 192'(12));
    chk("inv_alu", 192'(ex_alu_control), 192'(0));

    // stall counter saturation: 2^CW+2 load-use events
    for (int i = 0; i < (1 << CW) + 2; i++) begin
      cur = mk(1, 1, 5, 1, 0, 1, 0, 32'h300);
      tick("sat_lw");
      cur = mk(1, 0, 6, 2, 5, 0, 1, 32'h304);
      tick("sat_use");
    end
    chk("sat_scnt", 192'(stall_count), 192'({CW{1'b1}}));

    // reset overrides hold/flush mid-run
    rst = 1; hold = 1; flush = 1;
    tick("reset2");
    rst = 0; hold = 0; flush = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the RV32I 5-stage pipeline. Sits directly downstream of the control decoder and register file.
- Registers decoder control signals, operands, immediate and PC into EX.
- Detects load-use hazards and inserts one-cycle bubbles with an upstream stall.
- Kills the ID instruction on a taken branch/jump flush from EX.
- Keeps saturating stall/flush event counters.

Parameters:
XLEN, 32, datapath width
CNT_W, 16, width of stall/flush event counters

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
id_valid  input  1  ID holds a real instruction
id_reg_write  input  1  decoder reg_write
id_mem_to_reg  input  2  decoder writeback select
id_load  input  1  decoder Load
id_store  input  1  decoder Store
id_branch  input  1  decoder Branch
id_next_sel  input  1  decoder next_sel (jal/jalr)
id_operand_a  input  1  decoder ALU A select
id_operand_b  input  1  decoder ALU B select
id_mem_en  input  1  decoder mem_en
id_alu_control  input  4  decoder ALU op
id_fun3  input  3  instruction fun3
id_rs1  input  5  source register 1 address
id_rs2  input  5  source register 2 address
id_rd  input  5  destination register address
id_uses_rs1  input  1  instruction reads rs1
id_uses_rs2  input  1  instruction reads rs2
id_rs1_data  input  XLEN  register file read 1
id_rs2_data  input  XLEN  register file read 2
id_imm  input  XLEN  generated immediate
id_pc  input  XLEN  instruction PC
hold  input  1  downstream freeze request (EX/MEM busy)
flush  input  1  taken branch/jump resolved in EX
ex_*  output  (same widths)  registered copies of every id_* input above, plus ex_valid
stall  output  1  freeze PC and IF/ID this cycle
stall_count  output  CNT_W  load-use bubbles inserted, saturating
flush_count  output  CNT_W  flushes applied, saturating

Behaviour:
- All state updates on the rising edge of clk. stall is the only combinational output.
- Reset (rst=1 at an edge): every ex_* output goes to 0, including ex_valid, ex_alu_control and ex_mem_to_reg. Both counters go to 0. Reset overrides hold and flush.
- load_use: comb = ex_valid & ex_load & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)) & id_valid.
- stall = hold | (load_use & ~flush).
- Per-edge priority (rst not asserted):
  1. hold=1: all ex_* hold their values. Counters unchanged. hold outranks flush; the EX unit re-asserts flush after the hold releases.
  2. else flush=1: bubble captured. flush_count increments. No stall, because the ID instruction is wrong-path.
  3. else load_use=1: bubble captured. stall_count increments. stall=1, so IF/ID replays the same instruction next cycle. The load is then in MEM, so load_use clears and the instruction enters EX with a latency of one extra cycle.
  4. else: all id_* captured into ex_*, with ex_valid=id_valid.
- Bubble: ex_valid and every control output are 0; ex_rd, ex_rs1, ex_rs2, ex_fun3, data, imm and pc are 0. A bubble never writes registers or memory.
- Invalid ID (id_valid=0, case 4): fields are captured as presented. ex_valid=0 and control outputs are forced to 0.
- Counters saturate at all-ones with no wrap.
- Normal latency is exactly 1 cycle ID to EX.
- Back-to-back loads each stall at most 1 cycle per dependent consumer.
- rd=x0 never causes a stall.

Test Plan:
- Reset: drive rst=1 with nonzero id_* inputs -> next edge all ex_*=0, counters=0, stall=0.
- Passthrough: id_valid=1, add x3,x1,x2 (alu_control=0000, reg_write=1, rd=3, rs1_data=5, rs2_data=7), no hazard -> next cycle ex_alu_control=0000, ex_rd=3, ex_rs1_data=5, ex_rs2_data=7, ex_valid=1.
- Load-use: EX holds lw x5 (ex_load=1, ex_rd=5); ID presents add x6,x5,x1 -> stall=1, next edge a bubble is captured (ex_valid=0, ex_reg_write=0), stall_count=1; one cycle later the add is in EX.
- x0/unused source: EX has lw x0; ID reads rs1=0 -> stall=0. EX has lw x5; ID is lui x5 with uses_rs1=0 and uses_rs2=0 -> stall=0.
- Flush vs hazard: a load-use condition plus flush=1 in the same cycle -> stall=0, bubble captured, flush_count=1, stall_count unchanged.
- Hold priority: hold=1 with flush=1 for 3 cycles -> ex_* frozen, stall=1, counters unchanged. Drop hold with flush still 1 -> bubble on the next edge.
- Saturation: force 2^CNT_W+2 load-use events -> stall_count=all-ones, no wrap.
